// File: rtl/umac_bi_scaled_ctrl.sv
// rtl/umac_bi_scaled_ctrl.sv - sequencer for the 16-lane bipolar scaled unary MAC datapath
module umac_bi_scaled_ctrl #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 16,
    parameter int MAX_LOG_LEN = 10,
    parameter int PIPE        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [3:0]               w_idx,
    input  logic [WIDTH-1:0]         w_data,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [3:0]               start_log_len,
    output logic [LANES*WIDTH-1:0]   oB,
    output logic                     loadB,
    output logic                     src_clr,
    output logic                     src_en,
    input  logic                     mac_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [MAX_LOG_LEN:0]     res_ones,
    output logic [MAX_LOG_LEN+1:0]   res_data,
    output logic                     busy
);
    localparam int CW = MAX_LOG_LEN + 1;
    localparam logic [3:0]    MAX_LL     = 4'(MAX_LOG_LEN);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [LANES*WIDTH-1:0] bank;
    logic [CW-1:0]          len;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          ones;
    logic [PIPE-1:0]        en_pipe;
    logic [3:0]             log_eff;
    logic                   w_fire, start_fire, last_run, last_drain, cnt_en;

    assign log_eff    = (start_log_len > MAX_LL) ? MAX_LL : start_log_len;
    assign w_fire     = w_valid && w_ready;
    assign start_fire = start_valid && start_ready;
    assign last_run   = (cnt == len - CW'(1));
    assign last_drain = (cnt == DRAIN_LAST);
    // Counting lags src_en by the datapath latency so the window lines up with oC.
    assign cnt_en     = en_pipe[PIPE-1];

    always_comb begin
        state_nx    = state;
        w_ready     = 1'b0;
        start_ready = 1'b0;
        loadB       = 1'b0;
        src_clr     = 1'b0;
        src_en      = 1'b0;
        res_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                w_ready     = 1'b1;
                start_ready = 1'b1;
                if (start_valid) state_nx = S_LOAD;
            end
            S_LOAD: begin
                loadB    = 1'b1;
                src_clr  = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                src_en = 1'b1;
                if (last_run) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_drain) state_nx = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bank    <= '0;
            len     <= '0;
            cnt     <= '0;
            ones    <= '0;
            en_pipe <= '0;
        end else begin
            state <= state_nx;
            for (int i = 0; i < LANES; i++) begin
                if (w_fire && (w_idx == 4'(i))) bank[i*WIDTH +: WIDTH] <= w_data;
            end
            en_pipe[0] <= src_en;
            for (int i = 1; i < PIPE; i++) en_pipe[i] <= en_pipe[i-1];
            case (state)
                S_LOAD:  cnt <= '0;
                S_RUN:   cnt <= last_run ? '0 : cnt + CW'(1);
                S_DRAIN: cnt <= cnt + CW'(1);
                default: cnt <= cnt;
            endcase
            if (cnt_en && mac_out) ones <= ones + CW'(1);
            if (start_fire) begin
                len  <= CW'(1) << log_eff;
                ones <= '0;
            end
        end
    end

    assign oB       = bank;
    assign res_ones = ones;
    assign res_data = {ones, 1'b0} - {1'b0, len};
    assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_umac_bi_scaled_ctrl.sv
// tb/tb_umac_bi_scaled_ctrl.sv - scoreboard bench for umac_bi_scaled_ctrl
module tb_umac_bi_scaled_ctrl;
    localparam int WIDTH = 8, LANES = 16, MLL = 10, PIPE = 2;

    logic                   clk, rst;
    logic                   w_valid, w_ready;
    logic [3:0]             w_idx;
    logic [WIDTH-1:0]       w_data;
    logic                   start_valid, start_ready;
    logic [3:0]             start_log_len;
    logic [LANES*WIDTH-1:0] oB;
    logic                   loadB, src_clr, src_en, mac_out;
    logic                   res_valid, res_ready, busy;
    logic [MLL:0]           res_ones;
    logic [MLL+1:0]         res_data;

    umac_bi_scaled_ctrl #(.WIDTH(WIDTH), .LANES(LANES), .MAX_LOG_LEN(MLL), .PIPE(PIPE)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx), .w_data(w_data),
        .start_valid(start_valid), .start_ready(start_ready), .start_log_len(start_log_len),
        .oB(oB), .loadB(loadB), .src_clr(src_clr), .src_en(src_en), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_ones(res_ones),
        .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int cyc;
        int ones;
        int data;
    } exp_t;
    exp_t sb[$];

    int          errors = 0;
    int          checks = 0;
    int          job_base = -100000;
    logic [63:0] pat = '0;
    logic        mac_def = 1'b0;
    int          lb_cnt, lb_cyc, se_cnt, se_first, se_last;
    logic [7:0]  lb_w5;
    logic        rv_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mac_out for relative cycle k is driven during cycle k
    always @(posedge clk) begin
        int k;
        #2;
        k = ecnt - job_base;
        mac_out = (k >= 0 && k < 64) ? pat[k] : mac_def;
    end

    always @(negedge clk) begin
        int k;
        exp_t e;
        k = ecnt - job_base;
        if (loadB) begin
            lb_cnt++;
            lb_cyc = k;
            lb_w5  = oB[47:40];
        end
        if (src_en) begin
            if (se_cnt == 0) se_first = k;
            se_cnt++;
            se_last = k;
        end
        if (res_valid && !rv_q) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_cycle", k, e.cyc);
                check("res_ones", int'(res_ones), e.ones);
                check("res_data", int'($signed(res_data)), e.data);
            end
        end
        rv_q = res_valid;
    end

    task automatic expect_res(input int L, input int ones);
        exp_t e;
        e.cyc  = L + PIPE + 2;
        e.ones = ones;
        e.data = 2 * ones - L;
        sb.push_back(e);
    endtask

    task automatic start_job(input logic [3:0] ll, input logic [63:0] p, input logic d,
                             input logic wv, input logic [3:0] wi, input logic [7:0] wd);
        @(negedge clk);
        pat = p; mac_def = d;
        start_valid = 1'b1; start_log_len = ll;
        w_valid = wv; w_idx = wi; w_data = wd;
        lb_cnt = 0; se_cnt = 0; se_first = -1; se_last = -1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        w_valid = 1'b0;
        job_base = ecnt - 1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; w_valid = 1'b0; w_idx = '0; w_data = '0;
        start_valid = 1'b0; start_log_len = '0; res_ready = 1'b1; mac_out = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_w_ready", w_ready, 1);
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_loadB", loadB, 0);
        check("rst_src_en", src_en, 0);
        check("rst_oB_zero", int'(oB == '0), 1);
        check("rst_res_data", int'(res_data), 0);

        // L=8, mac_out tied 1, weight write accepted alongside start
        expect_res(8, 8);
        start_job(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'd5, 8'h7F);
        repeat (3) @(negedge clk);
        w_valid = 1'b1; w_idx = 4'd5; w_data = 8'h11;
        check("run_w_ready", w_ready, 0);
        check("run_start_ready", start_ready, 0);
        @(posedge clk);
        #1 w_valid = 1'b0;
        wait_idle();
        check("l8_loadB_count", lb_cnt, 1);
        check("l8_loadB_cycle", lb_cyc, 1);
        check("l8_oB_at_loadB", lb_w5, 8'h7F);
        check("l8_src_en_count", se_cnt, 8);
        check("l8_src_en_first", se_first, 2);
        check("l8_src_en_last", se_last, 9);
        check("bank_after_run_write", oB[47:40], 8'h7F);

        // L=16, mac_out tied 0
        expect_res(16, 0);
        start_job(4'd4, 64'h0, 1'b0, 1'b0, 4'd0, 8'h0);
        wait_idle();
        check("l16_src_en_count", se_cnt, 16);

        // L=4 window: ones only outside the window, then only inside
        expect_res(4, 0);
        start_job(4'd2, 64'h10C, 1'b0, 1'b0, 4'd0, 8'h0);
        wait_idle();
        expect_res(4, 4);
        start_job(4'd2, 64'hF0, 1'b0, 1'b0, 4'd0, 8'h0);
        wait_idle();

        // L=1 boundary, alternate ones inside window
        expect_res(1, 1);
        start_job(4'd0, 64'h10, 1'b0, 1'b0, 4'd0, 8'h0);
        wait_idle();
        check("l1_src_en_count", se_cnt, 1);

        // backpressure in DONE
        res_ready = 1'b0;
        expect_res(2, 2);
        start_job(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd0, 8'h0);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_res_valid_seen", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid_held", res_valid, 1);
            check("bp_res_data_held", int'($signed(res_data)), 2);
            check("bp_start_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_busy", busy, 0);
        check("bp_release_res_valid", res_valid, 0);

        // clamp: log_len 12 -> L=1024
        expect_res(1024, 1024);
        start_job(4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd0, 8'h0);
        wait_idle();
        check("clamp_src_en_count", se_cnt, 1024);
        check("clamp_src_en_first", se_first, 2);
        check("clamp_src_en_last", se_last, 1025);

        // reset mid-RUN abandons the job
        start_job(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd0, 8'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_src_en", src_en, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_oB_zero", int'(oB == '0), 1);
        check("mid_rst_w_ready", w_ready, 1);
        check("mid_rst_start_ready", start_ready, 1);
        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
